// File: rtl/trg_multi.sv
// trg_multi: merges N_SRC trigger sources into one accepted trigger stream.
// Busy combines dead time, minimum spacing, readout backlog and forced busy.
module trg_multi #(
    parameter int N_SRC   = 4,
    parameter int CNT_W   = 32,
    parameter int N_EVBUF = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             reg_we_i,
    input  logic [7:0]       reg_addr_i,
    input  logic [15:0]      reg_data_i,
    output logic [15:0]      reg_data_o,
    input  logic [N_SRC-1:0] trg_src_i,
    input  logic             extbsy_i,
    input  logic             rdo_done_i,
    output logic             trg_o,
    output logic             trg_req_o,
    output logic [N_SRC-1:0] trg_srcvec_o,
    output logic             bsy_o,
    output logic             bsy_fix_o,
    output logic             bsy_past_o,
    output logic             bsy_rdo_o,
    output logic             bsy_force_o,
    output logic [7:0]       evt_pending_o
);
    localparam logic [7:0] EVBUF = 8'(N_EVBUF);

    logic [N_SRC-1:0] prev_q, srcmask_q, srcmask_d, srcvec_q, edge_v;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] fixedbusy_q, fixedbusy_d, minsp_q, minsp_d;
    logic [CNT_W-1:0] dt_fix_q, dt_fix_d, dt_past_q, dt_past_d;
    logic [7:0]       evt_q, evt_d;
    logic [31:0]      reqcnt_q, reqcnt_d, acccnt_q, acccnt_d;
    logic [31:0]      fb32, ms32, fb_w, ms_w;
    logic             trg_q, req_q, req, acc, bsy, bsy_int;
    logic             bsy_fix, bsy_past, bsy_rdo, clr_evt, clr_cnt;

    assign edge_v   = trg_src_i & ~prev_q & srcmask_q;
    assign req      = |edge_v;
    assign bsy_fix  = |dt_fix_q;
    assign bsy_past = |dt_past_q;
    assign bsy_rdo  = evt_q >= EVBUF;
    assign bsy_int  = bsy_fix | bsy_past | bsy_rdo | ctrl_q[0];
    assign bsy      = (bsy_int & ~ctrl_q[2]) | (extbsy_i & ~ctrl_q[1]);
    assign acc      = req & ~bsy;

    assign clr_evt = reg_we_i && reg_addr_i == 8'h02 && reg_data_i == 16'h0000;
    assign clr_cnt = reg_we_i && reg_addr_i == 8'h02 && reg_data_i == 16'h0001;

    assign fb32 = 32'(fixedbusy_q);
    assign ms32 = 32'(minsp_q);
    assign fb_w = reg_addr_i[0] ? {reg_data_i, fb32[15:0]} : {fb32[31:16], reg_data_i};
    assign ms_w = reg_addr_i[0] ? {reg_data_i, ms32[15:0]} : {ms32[31:16], reg_data_i};

    always_comb begin
        ctrl_d      = (reg_we_i && reg_addr_i == 8'h01) ? reg_data_i[2:0] : ctrl_q;
        srcmask_d   = (reg_we_i && reg_addr_i == 8'h03) ? reg_data_i[N_SRC-1:0] : srcmask_q;
        fixedbusy_d = (reg_we_i && reg_addr_i[7:1] == 7'h02) ? fb_w[CNT_W-1:0] : fixedbusy_q;
        minsp_d     = (reg_we_i && reg_addr_i[7:1] == 7'h03) ? ms_w[CNT_W-1:0] : minsp_q;
        dt_fix_d    = acc ? fixedbusy_q : dt_fix_q - {{(CNT_W-1){1'b0}}, bsy_fix};
        dt_past_d   = req ? minsp_q : dt_past_q - {{(CNT_W-1){1'b0}}, bsy_past};
        // acc together with rdo_done cancels out; 255 only reachable with intbsy_msk
        evt_d       = clr_evt ? 8'd0 :
                      (acc && !rdo_done_i && evt_q != 8'hFF) ? evt_q + 8'd1 :
                      (!acc && rdo_done_i && evt_q != 8'd0) ? evt_q - 8'd1 : evt_q;
        reqcnt_d    = clr_cnt ? 32'd0 : reqcnt_q + 32'(req & ~&reqcnt_q);
        acccnt_d    = clr_cnt ? 32'd0 : acccnt_q + 32'(acc & ~&acccnt_q);
    end

    always_comb begin
        case (reg_addr_i)
            8'h00:   reg_data_o = {evt_q, 3'b000, bsy, bsy_rdo, bsy_past, bsy_fix, ctrl_q[0]};
            8'h01:   reg_data_o = {13'd0, ctrl_q};
            8'h02:   reg_data_o = 16'h0000;
            8'h03:   reg_data_o = 16'(srcmask_q);
            8'h04:   reg_data_o = fb32[15:0];
            8'h05:   reg_data_o = fb32[31:16];
            8'h06:   reg_data_o = ms32[15:0];
            8'h07:   reg_data_o = ms32[31:16];
            8'h08:   reg_data_o = reqcnt_q[15:0];
            8'h09:   reg_data_o = reqcnt_q[31:16];
            8'h0A:   reg_data_o = acccnt_q[15:0];
            8'h0B:   reg_data_o = acccnt_q[31:16];
            default: reg_data_o = 16'hF001;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q      <= '0;
            srcmask_q   <= '1;
            ctrl_q      <= 3'b001;
            fixedbusy_q <= '0;
            minsp_q     <= '0;
            dt_fix_q    <= '0;
            dt_past_q   <= '0;
            evt_q       <= '0;
            reqcnt_q    <= '0;
            acccnt_q    <= '0;
            trg_q       <= 1'b0;
            req_q       <= 1'b0;
            srcvec_q    <= '0;
        end else begin
            prev_q      <= trg_src_i;
            srcmask_q   <= srcmask_d;
            ctrl_q      <= ctrl_d;
            fixedbusy_q <= fixedbusy_d;
            minsp_q     <= minsp_d;
            dt_fix_q    <= dt_fix_d;
            dt_past_q   <= dt_past_d;
            evt_q       <= evt_d;
            reqcnt_q    <= reqcnt_d;
            acccnt_q    <= acccnt_d;
            trg_q       <= acc;
            req_q       <= req;
            srcvec_q    <= edge_v;
        end
    end

    assign trg_o         = trg_q;
    assign trg_req_o     = req_q;
    assign trg_srcvec_o  = srcvec_q;
    assign bsy_o         = bsy;
    assign bsy_fix_o     = bsy_fix;
    assign bsy_past_o    = bsy_past;
    assign bsy_rdo_o     = bsy_rdo;
    assign bsy_force_o   = ctrl_q[0];
    assign evt_pending_o = evt_q;
endmodule

// File: tb/tb_trg_multi.sv
// tb_trg_multi: directed checks of trg_multi with hand-computed expectations.
module tb_trg_multi;
    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        reg_we_i = 1'b0;
    logic [7:0]  reg_addr_i = 8'h00;
    logic [15:0] reg_data_i = 16'h0000, reg_data_o;
    logic [3:0]  trg_src_i = 4'h0, trg_srcvec_o;
    logic        extbsy_i = 1'b0, rdo_done_i = 1'b0;
    logic        trg_o, trg_req_o, bsy_o, bsy_fix_o, bsy_past_o, bsy_rdo_o, bsy_force_o;
    logic [7:0]  evt_pending_o;
    logic        r_req, r_trg;
    logic [3:0]  r_sv;
    int          n_chk = 0, n_err = 0;

    trg_multi #(.N_SRC(4), .CNT_W(32), .N_EVBUF(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
        .reg_data_i(reg_data_i), .reg_data_o(reg_data_o), .trg_src_i(trg_src_i),
        .extbsy_i(extbsy_i), .rdo_done_i(rdo_done_i), .trg_o(trg_o), .trg_req_o(trg_req_o),
        .trg_srcvec_o(trg_srcvec_o), .bsy_o(bsy_o), .bsy_fix_o(bsy_fix_o),
        .bsy_past_o(bsy_past_o), .bsy_rdo_o(bsy_rdo_o), .bsy_force_o(bsy_force_o),
        .evt_pending_o(evt_pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        reg_we_i = 1'b1; reg_addr_i = a; reg_data_i = d;
        tick();
        reg_we_i = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [15:0] exp);
        reg_addr_i = a;
        #1;
        chk(tag, 32'(reg_data_o), 32'(exp));
    endtask

    // edge seen at the first tick, outputs captured one cycle later, then one low sample
    task automatic pulse(input logic [3:0] m);
        trg_src_i = m;
        tick();
        r_req = trg_req_o; r_trg = trg_o; r_sv = trg_srcvec_o;
        trg_src_i = 4'h0;
        tick();
    endtask

    initial begin
        idle(2);
        rst_i = 1'b0;
        tick();
        chk("rst_bsy", 32'(bsy_o), 1);
        chk("rst_force", 32'(bsy_force_o), 1);
        chk("rst_trg", 32'(trg_o), 0);
        chk("rst_evt", 32'(evt_pending_o), 0);
        rd("rst_status", 8'h00, 16'h0011);
        rd("rst_srcmask", 8'h03, 16'h000F);
        rd("rst_ctrl", 8'h01, 16'h0001);
        rd("bad_addr", 8'h20, 16'hF001);
        rd("cmd_read", 8'h02, 16'h0000);

        pulse(4'h1);
        chk("forced_req", 32'(r_req), 1);
        chk("forced_trg", 32'(r_trg), 0);
        chk("forced_sv", 32'(r_sv), 1);
        chk("req_one_cycle", 32'(trg_req_o), 0);
        wr(8'h01, 16'h0000);
        chk("unforced_bsy", 32'(bsy_o), 0);
        pulse(4'h1);
        chk("first_acc", 32'(r_trg), 1);
        chk("trg_one_cycle", 32'(trg_o), 0);
        rd("acccnt1", 8'h0A, 16'h0001);
        rd("reqcnt2", 8'h08, 16'h0002);

        wr(8'h02, 16'h0001);
        wr(8'h02, 16'h0000);
        wr(8'h06, 16'd10);
        rd("minsp_rd", 8'h06, 16'd10);
        pulse(4'h1);
        chk("sp_acc_n", 32'(r_trg), 1);
        chk("sp_past", 32'(bsy_past_o), 1);
        idle(3);
        pulse(4'h2);
        chk("sp_req_n5", 32'(r_req), 1);
        chk("sp_rej_n5", 32'(r_trg), 0);
        idle(9);
        pulse(4'h1);
        chk("sp_acc_m11", 32'(r_trg), 1);
        wr(8'h02, 16'h0000);
        idle(7);
        pulse(4'h2);
        chk("sp_rej_p10", 32'(r_trg), 0);
        idle(9);
        pulse(4'h1);
        chk("sp_acc_p21", 32'(r_trg), 1);
        rd("sp_reqcnt", 8'h08, 16'd5);
        rd("sp_acccnt", 8'h0A, 16'd3);
        chk("sp_evt", 32'(evt_pending_o), 1);

        wr(8'h06, 16'd0);
        idle(12);
        wr(8'h02, 16'h0000);
        pulse(4'h1);
        chk("eb_acc1", 32'(r_trg), 1);
        pulse(4'h1);
        chk("eb_acc2", 32'(r_trg), 1);
        pulse(4'h1);
        chk("eb_rej3", 32'(r_trg), 0);
        chk("eb_req3", 32'(r_req), 1);
        chk("eb_rdo", 32'(bsy_rdo_o), 1);
        chk("eb_evt2", 32'(evt_pending_o), 2);
        rdo_done_i = 1'b1;
        tick();
        rdo_done_i = 1'b0;
        chk("eb_rdo_clr", 32'(bsy_rdo_o), 0);
        chk("eb_evt1", 32'(evt_pending_o), 1);
        trg_src_i = 4'h1; rdo_done_i = 1'b1;
        tick();
        trg_src_i = 4'h0; rdo_done_i = 1'b0;
        chk("eb_sim_trg", 32'(trg_o), 1);
        chk("eb_sim_evt", 32'(evt_pending_o), 1);
        tick();

        wr(8'h03, 16'h0005);
        wr(8'h02, 16'h0001);
        wr(8'h02, 16'h0000);
        trg_src_i = 4'hF;
        tick();
        chk("mask_req", 32'(trg_req_o), 1);
        chk("mask_sv", 32'(trg_srcvec_o), 32'h5);
        chk("mask_trg", 32'(trg_o), 1);
        trg_src_i = 4'h0;
        tick();
        chk("mask_sv_idle", 32'(trg_srcvec_o), 0);
        rd("mask_reqcnt", 8'h08, 16'd1);

        wr(8'h02, 16'h0000);
        extbsy_i = 1'b1;
        pulse(4'h1);
        chk("ext_req", 32'(r_req), 1);
        chk("ext_rej", 32'(r_trg), 0);
        wr(8'h01, 16'h0002);
        pulse(4'h1);
        chk("ext_msk_acc", 32'(r_trg), 1);
        extbsy_i = 1'b0;
        pulse(4'h4);
        chk("ext_acc2", 32'(r_trg), 1);
        chk("cmd_evt_pre", 32'(evt_pending_o), 2);
        wr(8'h02, 16'h0000);
        chk("cmd_evt_clr", 32'(evt_pending_o), 0);

        wr(8'h04, 16'd10);
        rd("fix_rd", 8'h04, 16'd10);
        wr(8'h01, 16'h0000);
        pulse(4'h1);
        chk("fix_acc", 32'(r_trg), 1);
        idle(2);
        chk("fix_bsy", 32'(bsy_fix_o), 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_fix", 32'(bsy_fix_o), 0);
        chk("arst_force", 32'(bsy_force_o), 1);
        rd("arst_status", 8'h00, 16'h0011);
        rd("arst_fixreg", 8'h04, 16'h0000);
        chk("arst_evt", 32'(evt_pending_o), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
